// File: rtl/inst_stats_monitor_pkg.sv
// Shared opcode, class, report-id and state definitions for the instruction statistics monitor.
// Also used by builds that define INST_STATS_OPCODE_HIST_EN.
package inst_stats_monitor_pkg;

   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_SUBI = 6'h03;
   localparam logic [5:0] OP_MUL  = 6'h04;
   localparam logic [5:0] OP_MULI = 6'h05;
   localparam logic [5:0] OP_OR   = 6'h06;
   localparam logic [5:0] OP_ORI  = 6'h07;
   localparam logic [5:0] OP_AND  = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h09;
   localparam logic [5:0] OP_XOR  = 6'h0A;
   localparam logic [5:0] OP_XORI = 6'h0B;
   localparam logic [5:0] OP_LDW  = 6'h0C;
   localparam logic [5:0] OP_STW  = 6'h0D;
   localparam logic [5:0] OP_BZ   = 6'h0E;
   localparam logic [5:0] OP_BEQ  = 6'h0F;
   localparam logic [5:0] OP_JR   = 6'h10;
   localparam logic [5:0] OP_HALT = 6'h11;

   localparam int unsigned NUM_OPCODES = 18;

   typedef enum logic [2:0] {ARITH, LOGICAL, MEMORY, CONTROL, ILLEGAL} inst_class_t;

   localparam logic [4:0] RPT_TOTAL     = 5'd0;
   localparam logic [4:0] RPT_ARITH     = 5'd1;
   localparam logic [4:0] RPT_LOGICAL   = 5'd2;
   localparam logic [4:0] RPT_MEMORY    = 5'd3;
   localparam logic [4:0] RPT_CONTROL   = 5'd4;
   localparam logic [4:0] RPT_ILLEGAL   = 5'd5;
   localparam logic [4:0] RPT_HIST_BASE = 5'd6;

   typedef enum logic [2:0] {IDLE, COUNT, DRAIN, REPORT, DONE} state_t;

endpackage

// File: rtl/inst_stats_monitor_classify.sv
// Combinational opcode classifier: maps a 6-bit opcode to its instruction class and flags HALT.
module inst_classify
   import inst_stats_monitor_pkg::*;
(
   input  logic [5:0]  opcode,
   output inst_class_t inst_class,
   output logic        is_halt
);

   always_comb begin
      inst_class = ILLEGAL;
      if (opcode <= OP_MULI)      inst_class = ARITH;
      else if (opcode <= OP_XORI) inst_class = LOGICAL;
      else if (opcode <= OP_STW)  inst_class = MEMORY;
      else if (opcode <= OP_HALT) inst_class = CONTROL;
   end

   assign is_halt = (opcode == OP_HALT);

endmodule

// File: rtl/inst_stats_monitor.sv
// Counts fetched instructions per opcode class, then streams the counters as {id, count} records.
// Define INST_STATS_OPCODE_HIST_EN to add per-opcode histogram records (ids 6-23).
module inst_stats_monitor
   import inst_stats_monitor_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [31:0]      inst_in,
   input  logic             opr_finished,
   input  logic             rpt_ready,
   output logic             rpt_valid,
   output logic [4:0]       rpt_id,
   output logic [CNT_W-1:0] rpt_data,
   output logic [CNT_W-1:0] total_cnt,
   output logic             halt_seen,
   output logic             done
);

`ifdef INST_STATS_OPCODE_HIST_EN
   localparam logic [4:0] LAST_ID = RPT_HIST_BASE + 5'(NUM_OPCODES - 1);
`else
   localparam logic [4:0] LAST_ID = RPT_ILLEGAL;
`endif
   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       drain_q, drain_d;
   logic [4:0]       idx_q, idx_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] cls_q [5];
   logic [CNT_W-1:0] rpt_mux;
   inst_class_t      cls;
   logic             is_halt;
   logic             count_en;
   logic             stop;
   logic [5:0]       opcode;
   logic             unused_inst;

   assign opcode      = inst_in[31:26];
   assign unused_inst = ^inst_in[25:0];

   inst_classify u_classify (
      .opcode     (opcode),
      .inst_class (cls),
      .is_halt    (is_halt)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign count_en = valid && (state_q == IDLE || state_q == COUNT);
   // A counted HALT and an external finish may coincide; both collapse into one move to DRAIN.
   assign stop     = (count_en && is_halt) || opr_finished;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      idx_d   = idx_q;
      halt_d  = halt_q;
      case (state_q)
         IDLE, COUNT: begin
            if (count_en) state_d = COUNT;
            if (count_en && is_halt) halt_d = 1'b1;
            if (stop) begin
               state_d = DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (drain_q == 8'd0) state_d = REPORT;
            else                 drain_d = drain_q - 8'd1;
         end
         REPORT: begin
            if (rpt_ready) begin
               if (idx_q == LAST_ID) state_d = DONE;
               else                  idx_d   = idx_q + 5'd1;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         drain_q <= '0;
         idx_q   <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         idx_q   <= idx_d;
         halt_q  <= halt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         total_q <= '0;
         for (int i = 0; i < 5; i++) cls_q[i] <= '0;
      end else if (count_en) begin
         total_q    <= sat_inc(total_q);
         cls_q[cls] <= sat_inc(cls_q[cls]);
      end
   end

`ifdef INST_STATS_OPCODE_HIST_EN
   logic [CNT_W-1:0] hist_q [NUM_OPCODES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_OPCODES); i++) hist_q[i] <= '0;
      end else if (count_en && cls != ILLEGAL) begin
         hist_q[opcode[4:0]] <= sat_inc(hist_q[opcode[4:0]]);
      end
   end
`endif

   always_comb begin
      rpt_mux = '0;
      case (idx_q)
         RPT_TOTAL:   rpt_mux = total_q;
         RPT_ARITH:   rpt_mux = cls_q[ARITH];
         RPT_LOGICAL: rpt_mux = cls_q[LOGICAL];
         RPT_MEMORY:  rpt_mux = cls_q[MEMORY];
         RPT_CONTROL: rpt_mux = cls_q[CONTROL];
         RPT_ILLEGAL: rpt_mux = cls_q[ILLEGAL];
         default: begin
`ifdef INST_STATS_OPCODE_HIST_EN
            if (idx_q >= RPT_HIST_BASE && idx_q <= LAST_ID) begin
               rpt_mux = hist_q[idx_q - RPT_HIST_BASE];
            end
`endif
         end
      endcase
   end

   assign rpt_valid = (state_q == REPORT);
   assign rpt_id    = rpt_valid ? idx_q : '0;
   assign rpt_data  = rpt_valid ? rpt_mux : '0;
   assign total_cnt = total_q;
   assign halt_seen = halt_q;
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_inst_stats_monitor.sv
// Directed self-checking bench for inst_stats_monitor; a CNT_W=4 instance shares the stimulus.
module tb_inst_stats_monitor;
   import inst_stats_monitor_pkg::*;

`ifdef INST_STATS_OPCODE_HIST_EN
   localparam int NREC = 24;
`else
   localparam int NREC = 6;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] inst_in = '0;
   logic        opr_finished = 1'b0;
   logic        rpt_ready = 1'b0;

   logic        rpt_valid, halt_seen, done;
   logic [4:0]  rpt_id;
   logic [31:0] rpt_data, total_cnt;
   logic        rpt_valid4, halt_seen4, done4;
   logic [4:0]  rpt_id4;
   logic [3:0]  rpt_data4, total_cnt4;

   int errors = 0;
   int checks = 0;
   logic [31:0] rec_id [24];
   logic [31:0] rec_data [24];
   logic [31:0] rec_data4 [24];
   int rec_n;

   inst_stats_monitor dut (
      .clk (clk), .reset (reset), .valid (valid), .inst_in (inst_in),
      .opr_finished (opr_finished), .rpt_ready (rpt_ready), .rpt_valid (rpt_valid),
      .rpt_id (rpt_id), .rpt_data (rpt_data), .total_cnt (total_cnt),
      .halt_seen (halt_seen), .done (done)
   );

   inst_stats_monitor #(.CNT_W(4)) dut_w4 (
      .clk (clk), .reset (reset), .valid (valid), .inst_in (inst_in),
      .opr_finished (opr_finished), .rpt_ready (rpt_ready), .rpt_valid (rpt_valid4),
      .rpt_id (rpt_id4), .rpt_data (rpt_data4), .total_cnt (total_cnt4),
      .halt_seen (halt_seen4), .done (done4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic fin);
      valid = 1'b1;
      inst_in = {op, 26'h155_5555};
      opr_finished = fin;
      tick();
      valid = 1'b0;
      opr_finished = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      opr_finished = 1'b0;
      rpt_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rpt_valid"}, 32'(rpt_valid), 32'd0);
      check({tag, "_rpt_id"}, 32'(rpt_id), 32'd0);
      check({tag, "_rpt_data"}, rpt_data, 32'd0);
      check({tag, "_total_cnt"}, total_cnt, 32'd0);
      check({tag, "_halt_seen"}, 32'(halt_seen), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Waits out DRAIN, then accepts records; stalls rpt_ready for 3 cycles at stall_id.
   task automatic collect(input int stall_id);
      int stall_n = 0;
      int last_acc = -1;
      int done_at = -1;
      logic [4:0]  sid = '0;
      logic [31:0] sdata = '0;
      rec_n = 0;
      for (int cyc = 0; cyc < 80 && done_at < 0; cyc++) begin
         if (rpt_valid && int'(rpt_id) == stall_id && stall_n < 3) begin
            rpt_ready = 1'b0;
            if (stall_n == 0) begin
               sid = rpt_id;
               sdata = rpt_data;
            end else begin
               check("stall_id", 32'(rpt_id), 32'(sid));
               check("stall_data", rpt_data, sdata);
            end
            stall_n++;
         end else begin
            rpt_ready = 1'b1;
         end
         if (rpt_valid && rpt_ready && rec_n < 24) begin
            rec_id[rec_n] = 32'(rpt_id);
            rec_data[rec_n] = rpt_data;
            rec_data4[rec_n] = 32'(rpt_data4);
            rec_n++;
            last_acc = cyc;
         end
         tick();
         if (done) done_at = cyc;
      end
      rpt_ready = 1'b0;
      check("done_reached", 32'(done), 32'd1);
      check("rec_count", 32'(rec_n), 32'(NREC));
      check("done_next_cycle", 32'(done_at - last_acc), 32'd0);
      check("rpt_valid_after_done", 32'(rpt_valid), 32'd0);
   endtask

   task automatic check_recs(input logic sel4, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input logic [31:0] e4, input logic [31:0] e5);
      logic [31:0] e [6];
      e = '{e0, e1, e2, e3, e4, e5};
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rec%0d_id", i), rec_id[i], 32'(i));
         check($sformatf("rec%0d_data%s", i, sel4 ? "_w4" : ""),
               sel4 ? rec_data4[i] : rec_data[i], e[i]);
      end
   endtask

   initial begin
      // Run 1: ADD, ADDI, LDW, BEQ, HALT back to back.
      do_reset();
      check_outputs_zero("reset");
      check("reset_total_w4", 32'(total_cnt4), 32'd0);
      issue(OP_ADD, 1'b0);
      issue(OP_ADDI, 1'b0);
      issue(OP_LDW, 1'b0);
      issue(OP_BEQ, 1'b0);
      issue(OP_HALT, 1'b0);
      check("r1_total", total_cnt, 32'd5);
      check("r1_halt_seen", 32'(halt_seen), 32'd1);
      tick();
      tick();
      tick();
      check("r1_drain_still", 32'(rpt_valid), 32'd0);
      tick();
      check("r1_report_start", 32'(rpt_valid), 32'd1);
      check("r1_first_data", rpt_data, 32'd5);
      collect(-1);
      check_recs(1'b0, 32'd5, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0);
      valid = 1'b1;
      inst_in = {OP_HALT, 26'h0};
      opr_finished = 1'b1;
      tick();
      tick();
      tick();
      valid = 1'b0;
      opr_finished = 1'b0;
      check("r1_done_sticky", 32'(done), 32'd1);
      check("r1_total_frozen", total_cnt, 32'd5);

      // Run 2: gapped illegal and logical, then external finish; stall at id 2.
      do_reset();
      check("r2_fresh_total", total_cnt, 32'd0);
      issue(6'h3F, 1'b0);
      tick();
      issue(OP_ORI, 1'b0);
      tick();
      opr_finished = 1'b1;
      tick();
      opr_finished = 1'b0;
      check("r2_halt_seen", 32'(halt_seen), 32'd0);
      collect(2);
      check_recs(1'b0, 32'd2, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1);

      // Run 3: wrong-path ADDs during DRAIN are ignored.
      do_reset();
      issue(OP_HALT, 1'b0);
      valid = 1'b1;
      inst_in = {OP_ADD, 26'h0};
      opr_finished = 1'b1;
      tick();
      tick();
      tick();
      valid = 1'b0;
      opr_finished = 1'b0;
      check("r3_total", total_cnt, 32'd1);
      collect(-1);
      check_recs(1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0);

      // Run 4: 17 ADDs then HALT; the 4-bit instance saturates.
      do_reset();
      for (int i = 0; i < 17; i++) issue(OP_ADD, 1'b0);
      issue(OP_HALT, 1'b0);
      check("r4_total_w4", 32'(total_cnt4), 32'd15);
      check("r4_total_w32", total_cnt, 32'd18);
      collect(-1);
      check_recs(1'b1, 32'd15, 32'd15, 32'd0, 32'd0, 32'd1, 32'd0);
      check_recs(1'b0, 32'd18, 32'd17, 32'd0, 32'd0, 32'd1, 32'd0);

      // Run 5: reset mid-REPORT, then a fresh run with valid+HALT+finish together.
      do_reset();
      issue(OP_ADD, 1'b0);
      issue(OP_HALT, 1'b0);
      rpt_ready = 1'b1;
      for (int i = 0; i < 10 && !rpt_valid; i++) tick();
      check("r5_report_reached", 32'(rpt_valid), 32'd1);
      tick();
      tick();
      tick();
      check("r5_mid_id", 32'(rpt_id), 32'd3);
      reset = 1'b1;
      tick();
      check_outputs_zero("r5_reset");
      reset = 1'b0;
      rpt_ready = 1'b0;
      issue(OP_STW, 1'b0);
      issue(OP_HALT, 1'b1);
      check("r5_total", total_cnt, 32'd2);
      check("r5_halt_seen", 32'(halt_seen), 32'd1);
      collect(-1);
      check_recs(1'b0, 32'd2, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
